// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: access-size encoding, width defaults
// and the alignment rule.
package mem_stage_pkg;

   localparam int INST_SZ_DFLT    = 32;
   localparam int MEM_ADDR_W_DFLT = 8;
   localparam int REG_ADDR_W      = 5;
   localparam int BHW_W           = 3;
   localparam int BHW_ZEXT        = 2;   // bhw bit selecting zero- instead of sign-extension

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_RSVD = 2'b10,   // decoded as a word access
      SZ_WORD = 2'b11
   } access_size_e;

   function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      case (sz)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lane[0];
         default: mis = |lane;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data RAM with per-byte write enables, asynchronous read port and
// a registered debug read port that always returns pre-write contents.
import mem_stage_pkg::*;

module data_memory #(
   parameter int INST_SZ    = INST_SZ_DFLT,
   parameter int MEM_ADDR_W = MEM_ADDR_W_DFLT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [INST_SZ/8-1:0]    byte_en,
   input  logic [MEM_ADDR_W-1:0]   addr,
   input  logic [INST_SZ-1:0]      wr_data,
   output logic [INST_SZ-1:0]      rd_data,
   input  logic [MEM_ADDR_W-1:0]   dbg_addr,
   output logic [INST_SZ-1:0]      dbg_data
);

   localparam int LANES = INST_SZ / 8;
   localparam int DEPTH = 1 << MEM_ADDR_W;

   logic [INST_SZ-1:0] mem [DEPTH];

   // No reset on the array: contents survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (byte_en[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (reset) dbg_data <= '0;
      else       dbg_data <= mem[dbg_addr];
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: access sizing, load extension, optional alignment check
// (MEM_ALIGN_CHECK_EN) and the MEM/WB pipeline register around data_memory.
import mem_stage_pkg::*;

module mem_stage #(
   parameter int INST_SZ    = INST_SZ_DFLT,
   parameter int MEM_ADDR_W = MEM_ADDR_W_DFLT
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_halt,
   input  logic                    i_mem_write,
   input  logic                    i_reg_write,
   input  logic                    i_mem_to_reg,
   input  logic                    i_bds_sel,
   input  logic [BHW_W-1:0]        i_bhw,
   input  logic [INST_SZ-1:0]      i_alu_result,
   input  logic [INST_SZ-1:0]      i_write_data,
   input  logic [REG_ADDR_W-1:0]   i_write_register,
   input  logic [INST_SZ-1:0]      i_bds,
   input  logic [MEM_ADDR_W-1:0]   i_dbg_addr,
   output logic [INST_SZ-1:0]      o_dbg_data,
   output logic                    o_halt,
   output logic                    o_reg_write,
   output logic                    o_mem_to_reg,
   output logic                    o_bds_sel,
   output logic [INST_SZ-1:0]      o_read_data,
   output logic [INST_SZ-1:0]      o_alu_result,
   output logic [REG_ADDR_W-1:0]   o_write_register,
   output logic [INST_SZ-1:0]      o_bds,
   output logic                    o_misaligned
);

   localparam int LANES = INST_SZ / 8;

   access_size_e           size;
   logic [1:0]             lane;
   logic [MEM_ADDR_W-1:0]  word_addr;
   logic                   misaligned;
   logic                   store_en;
   logic                   zext;
   logic [LANES-1:0]       byte_en;
   logic [INST_SZ-1:0]     wr_data;
   logic [INST_SZ-1:0]     rd_data;
   logic [7:0]             rd_byte;
   logic [15:0]            rd_half;
   logic [INST_SZ-1:0]     load_data;
   logic                   unused_addr_hi;

   assign size           = access_size_e'(i_bhw[1:0]);
   assign zext           = i_bhw[BHW_ZEXT];
   assign lane           = i_alu_result[1:0];
   assign word_addr      = i_alu_result[MEM_ADDR_W+1:2];
   assign unused_addr_hi = ^i_alu_result[INST_SZ-1:MEM_ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = is_misaligned(size, lane);
`else
   assign misaligned = 1'b0;
`endif

   assign store_en = i_enable & i_mem_write & ~i_reset & ~misaligned;

   // Narrow stores replicate the data across lanes; byte_en picks the target.
   always_comb begin
      byte_en = '0;
      wr_data = i_write_data;
      case (size)
         SZ_BYTE: begin
            byte_en[lane] = 1'b1;
            wr_data       = {LANES{i_write_data[7:0]}};
         end
         SZ_HALF: begin
            byte_en[2*lane[1] +: 2] = 2'b11;
            wr_data                 = {(LANES/2){i_write_data[15:0]}};
         end
         default: byte_en = '1;
      endcase
   end

   data_memory #(
      .INST_SZ    (INST_SZ),
      .MEM_ADDR_W (MEM_ADDR_W)
   ) u_data_memory (
      .clk      (i_clk),
      .reset    (i_reset),
      .wr_en    (store_en),
      .byte_en  (byte_en),
      .addr     (word_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .dbg_addr (i_dbg_addr),
      .dbg_data (o_dbg_data)
   );

   assign rd_byte = rd_data[8*lane +: 8];
   assign rd_half = rd_data[16*lane[1] +: 16];

   always_comb begin
      load_data = rd_data;
      case (size)
         SZ_BYTE: load_data = {{(INST_SZ-8){~zext & rd_byte[7]}}, rd_byte};
         SZ_HALF: load_data = {{(INST_SZ-16){~zext & rd_half[15]}}, rd_half};
         default: load_data = rd_data;
      endcase
      if (misaligned) load_data = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_halt           <= 1'b0;
         o_reg_write      <= 1'b0;
         o_mem_to_reg     <= 1'b0;
         o_bds_sel        <= 1'b0;
         o_read_data      <= '0;
         o_alu_result     <= '0;
         o_write_register <= '0;
         o_bds            <= '0;
         o_misaligned     <= 1'b0;
      end else if (i_enable) begin
         o_halt           <= i_halt;
         o_reg_write      <= i_reg_write;
         o_mem_to_reg     <= i_mem_to_reg;
         o_bds_sel        <= i_bds_sel;
         o_read_data      <= load_data;
         o_alu_result     <= i_alu_result;
         o_write_register <= i_write_register;
         o_bds            <= i_bds;
         o_misaligned     <= misaligned;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with scoreboard, plus stall,
// debug-port and reset sequences. Expectations follow MEM_ALIGN_CHECK_EN when defined.
module tb_mem_stage;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, enable, halt, mem_write, reg_write, mem_to_reg, bds_sel;
   logic [2:0]  bhw;
   logic [31:0] alu_result, write_data, bds;
   logic [4:0]  write_register;
   logic [7:0]  dbg_addr;
   logic [31:0] dbg_data, read_data, alu_out, bds_out;
   logic        halt_out, reg_write_out, mem_to_reg_out, bds_sel_out, misaligned;
   logic [4:0]  wreg_out;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_halt(halt),
      .i_mem_write(mem_write), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
      .i_bds_sel(bds_sel), .i_bhw(bhw), .i_alu_result(alu_result),
      .i_write_data(write_data), .i_write_register(write_register), .i_bds(bds),
      .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data), .o_halt(halt_out),
      .o_reg_write(reg_write_out), .o_mem_to_reg(mem_to_reg_out), .o_bds_sel(bds_sel_out),
      .o_read_data(read_data), .o_alu_result(alu_out), .o_write_register(wreg_out),
      .o_bds(bds_out), .o_misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          wr;
      logic [2:0]  bhw;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk_rd;
      logic [31:0] rd;
      bit          mis;
   } vec_t;

   typedef struct {
      string       name;
      bit          chk_rd;
      logic [31:0] rd;
      bit          mis;
      logic [31:0] alu;
      logic [31:0] bds;
      logic [4:0]  wreg;
      logic [3:0]  ctrl;
   } exp_t;

   vec_t vecs[32];
   int   nvec = 0;
   exp_t sb[$];
   exp_t last;

   task automatic add(input string n, input bit wr, input logic [2:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input bit c, input logic [31:0] rd, input bit mis);
      vecs[nvec] = '{n, wr, b, a, wd, c, rd, mis};
      nvec++;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ctrl_out();
      return {halt_out, reg_write_out, mem_to_reg_out, bds_sel_out};
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b1; halt = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
      mem_to_reg = 1'b1; bds_sel = 1'b1; bhw = 3'b011; alu_result = 32'h1234;
      write_data = 32'hFFFF_FFFF; write_register = 5'd9; bds = 32'hCAFE_0000; dbg_addr = 8'd0;

      add("st_w10",  1, 3'b011, 32'h10,  32'hDEADBEEF, 0, 32'h0, 0);
      add("ld_w10",  0, 3'b011, 32'h10,  32'h0,        1, 32'hDEADBEEF, 0);
      add("st_w20",  1, 3'b011, 32'h20,  32'h0,        0, 32'h0, 0);
      add("st_b21",  1, 3'b000, 32'h21,  32'h80,       0, 32'h0, 0);
      add("ld_b21s", 0, 3'b000, 32'h21,  32'h0,        1, 32'hFFFFFF80, 0);
      add("ld_b21z", 0, 3'b100, 32'h21,  32'h0,        1, 32'h00000080, 0);
      add("ld_h22",  0, 3'b001, 32'h22,  32'h0,        1, 32'h00000000, 0);
      add("ld_h20s", 0, 3'b001, 32'h20,  32'h0,        1, 32'hFFFF8000, 0);
      add("ld_h20z", 0, 3'b101, 32'h20,  32'h0,        1, 32'h00008000, 0);
      add("st_w30",  1, 3'b011, 32'h30,  32'h11223344, 0, 32'h0, 0);
      add("st_h32",  1, 3'b001, 32'h32,  32'hA5A5CAFE, 0, 32'h0, 0);
      add("ld_w30",  0, 3'b011, 32'h30,  32'h0,        1, 32'hCAFE3344, 0);
      add("ld_b33z", 0, 3'b100, 32'h33,  32'h0,        1, 32'h000000CA, 0);
      add("ld_b31s", 0, 3'b000, 32'h31,  32'h0,        1, 32'h00000033, 0);
      add("ld_wrap", 0, 3'b011, 32'h430, 32'h0,        1, 32'hCAFE3344, 0);
      add("st_w40r", 1, 3'b010, 32'h40,  32'h55667788, 0, 32'h0, 0);
      add("ld_w40",  0, 3'b011, 32'h40,  32'h0,        1, 32'h55667788, 0);
      add("st_w50",  1, 3'b011, 32'h50,  32'h0,        0, 32'h0, 0);
      add("st_w60",  1, 3'b011, 32'h60,  32'h0BADF00D, 0, 32'h0, 0);
      add("st_w00",  1, 3'b011, 32'h00,  32'h89ABCDEF, 0, 32'h0, 0);
      add("ld_h03",  0, 3'b001, 32'h03,  32'h0,        1, ALN ? 32'h0 : 32'hFFFF89AB, ALN);
      add("st_h03",  1, 3'b001, 32'h03,  32'h1234,     1, ALN ? 32'h0 : 32'hFFFF89AB, ALN);
      add("ld_w00",  0, 3'b011, 32'h00,  32'h0,        1, ALN ? 32'h89ABCDEF : 32'h1234CDEF, 0);
      add("ld_w01",  0, 3'b011, 32'h01,  32'h0,        1, ALN ? 32'h0 : 32'h1234CDEF, ALN);
      add("ld_b03s", 0, 3'b000, 32'h03,  32'h0,        1, ALN ? 32'hFFFFFF89 : 32'h00000012, 0);

      // reset state
      step();
      step();
      chk("rst_rd",   read_data, 32'h0);
      chk("rst_alu",  alu_out, 32'h0);
      chk("rst_bds",  bds_out, 32'h0);
      chk("rst_wreg", {27'h0, wreg_out}, 32'h0);
      chk("rst_ctrl", {28'h0, ctrl_out()}, 32'h0);
      chk("rst_mis",  {31'h0, misaligned}, 32'h0);
      chk("rst_dbg",  dbg_data, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < nvec; i++) begin
         exp_t e;
         logic [3:0] c;
         c = i[3:0] ^ 4'b1010;
         {halt, reg_write, mem_to_reg, bds_sel} = c;
         enable = 1'b1;
         mem_write = vecs[i].wr;
         bhw = vecs[i].bhw;
         alu_result = vecs[i].addr;
         write_data = vecs[i].wdata;
         write_register = 5'(i + 3);
         bds = 32'h1000 + 32'(i * 4);
         e = '{vecs[i].name, vecs[i].chk_rd, vecs[i].rd, vecs[i].mis,
               vecs[i].addr, 32'h1000 + 32'(i * 4), 5'(i + 3), c};
         sb.push_back(e);
         step();
         if (sb.size() == 0) begin
            chk("sb_empty", 32'h0, 32'h1);
         end else begin
            e = sb.pop_front();
            last = e;
            if (e.chk_rd) chk({e.name, "_rd"}, read_data, e.rd);
            chk({e.name, "_mis"},  {31'h0, misaligned}, {31'h0, e.mis});
            chk({e.name, "_alu"},  alu_out, e.alu);
            chk({e.name, "_bds"},  bds_out, e.bds);
            chk({e.name, "_wreg"}, {27'h0, wreg_out}, {27'h0, e.wreg});
            chk({e.name, "_ctrl"}, {28'h0, ctrl_out()}, {28'h0, e.ctrl});
         end
      end

      // stall: store suppressed, outputs hold
      enable = 1'b0; mem_write = 1'b1; bhw = 3'b011; alu_result = 32'h50;
      write_data = 32'h12345678; write_register = 5'd31; bds = 32'hFFFF;
      {halt, reg_write, mem_to_reg, bds_sel} = 4'b1111; dbg_addr = 8'h14;
      step();
      chk("stall_rd",   read_data, last.rd & {32{last.chk_rd}} | read_data & {32{~last.chk_rd}});
      chk("stall_alu",  alu_out, last.alu);
      chk("stall_bds",  bds_out, last.bds);
      chk("stall_wreg", {27'h0, wreg_out}, {27'h0, last.wreg});
      chk("stall_ctrl", {28'h0, ctrl_out()}, {28'h0, last.ctrl});
      chk("stall_mis",  {31'h0, misaligned}, {31'h0, last.mis});
      mem_write = 1'b0;
      step();
      chk("stall_mem", dbg_data, 32'h0);
      enable = 1'b1; mem_write = 1'b1;
      step();
      chk("unstall_dbg_old", dbg_data, 32'h0);
      mem_write = 1'b0;
      step();
      chk("unstall_rd",  read_data, 32'h12345678);
      chk("unstall_dbg", dbg_data, 32'h12345678);

      // debug port sees old data on a same-cycle store
      dbg_addr = 8'd4; mem_write = 1'b1; alu_result = 32'h10; write_data = 32'h11;
      step();
      chk("dbg_old", dbg_data, 32'hDEADBEEF);
      mem_write = 1'b0;
      step();
      chk("dbg_new", dbg_data, 32'h00000011);

      // reset during a store
      dbg_addr = 8'h18; reset = 1'b1; enable = 1'b1; mem_write = 1'b1; alu_result = 32'h60;
      write_data = 32'hAAAA5555; write_register = 5'd7; bds = 32'h4444;
      {halt, reg_write, mem_to_reg, bds_sel} = 4'b1111;
      step();
      chk("mrst_rd",   read_data, 32'h0);
      chk("mrst_alu",  alu_out, 32'h0);
      chk("mrst_bds",  bds_out, 32'h0);
      chk("mrst_wreg", {27'h0, wreg_out}, 32'h0);
      chk("mrst_ctrl", {28'h0, ctrl_out()}, 32'h0);
      chk("mrst_mis",  {31'h0, misaligned}, 32'h0);
      chk("mrst_dbg",  dbg_data, 32'h0);
      reset = 1'b0; mem_write = 1'b0;
      step();
      chk("mrst_keep_rd",  read_data, 32'h0BADF00D);
      chk("mrst_keep_dbg", dbg_data, 32'h0BADF00D);
      chk("mrst_alu_back", alu_out, 32'h60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
